// File: rtl/button_conditioner.sv
// Per-button 2-FF synchronizer, counter-based debouncer and rising-edge pulse generator.
// Optional feature macro: AUTO_REPEAT_EN (press-and-hold repeat pulses on btn_re).
module button_conditioner #(
  parameter int unsigned NUM_BUTTONS     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                   clk,
  input  logic                   sync_reset,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_re
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_ONE         = RPT_W'(1);
`endif

  // Elaboration-time parameter sanity checks
  if (NUM_BUTTONS < 1) begin : g_chk_nb
    $error("NUM_BUTTONS must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 1) begin : g_chk_rd
    $error("REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_PERIOD < 2) begin : g_chk_rp
    $error("REPEAT_PERIOD must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } deb_state_t;

  logic [NUM_BUTTONS-1:0] sync1;
  logic [NUM_BUTTONS-1:0] sync2;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  genvar g;
  for (g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             re_q;
`ifdef AUTO_REPEAT_EN
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_period;
`endif

    // Debounce FSM; btn_re only ever fires on press acceptance (or repeat)
    always_ff @(posedge clk) begin
      if (sync_reset) begin
        state   <= IDLE_LOW;
        cnt     <= '0;
        level_q <= 1'b0;
        re_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
        rpt_cnt    <= '0;
        rpt_period <= 1'b0;
`endif
      end else begin
        re_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
        if (state != IDLE_HIGH) begin
          rpt_cnt    <= '0;
          rpt_period <= 1'b0;
        end
`endif
        case (state)
          IDLE_LOW: begin
            if (sync2[g]) begin
              state <= WAIT_HIGH;
              cnt   <= CNT_ONE;
            end
          end
          WAIT_HIGH: begin
            if (!sync2[g]) begin
              state <= IDLE_LOW;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state   <= IDLE_HIGH;
              cnt     <= '0;
              level_q <= 1'b1;
              re_q    <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          IDLE_HIGH: begin
            if (!sync2[g]) begin
              state <= WAIT_LOW;
              cnt   <= CNT_ONE;
            end
`ifdef AUTO_REPEAT_EN
            // First repeat after the delay, then one per period while held
            else if (rpt_cnt == (rpt_period ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
              re_q       <= 1'b1;
              rpt_cnt    <= '0;
              rpt_period <= 1'b1;
            end else begin
              rpt_cnt <= rpt_cnt + RPT_ONE;
            end
`endif
          end
          WAIT_LOW: begin
            if (sync2[g]) begin
              state <= IDLE_HIGH;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state   <= IDLE_LOW;
              cnt     <= '0;
              level_q <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign btn_level[g] = level_q;
    assign btn_re[g]    = re_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus randomized
// stimulus compared against a run-length reference model of the debouncer.
module tb_button_conditioner;

  localparam int unsigned NB = 2;
  localparam int unsigned DC = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;

  logic          clk = 1'b0;
  logic          sync_reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_re;

  int errors = 0;
  int checks = 0;

  // Reference model state: raw delayed two samples, accepted level, length of
  // the current run of samples disagreeing with it, and cycles held while stable.
  logic [NB-1:0] m_s1, m_s2, m_level, m_re;
  int            m_run  [NB];
  int            m_hold [NB];

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BUTTONS    (NB),
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .sync_reset(sync_reset),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_re    (btn_re)
  );

  function automatic void model_edge(input logic [NB-1:0] raw, input logic rst);
    logic [NB-1:0] sv;
    logic          stable_high;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_re = '0;
      for (int c = 0; c < NB; c++) begin
        m_run[c] = 0; m_hold[c] = 0;
      end
    end else begin
      sv   = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      for (int c = 0; c < NB; c++) begin
        stable_high = m_level[c] && (m_run[c] == 0);
        m_re[c] = 1'b0;
        if (sv[c] != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == int'(DC)) begin
            m_level[c] = sv[c];
            m_run[c]   = 0;
            m_re[c]    = sv[c];
          end
        end else begin
          m_run[c] = 0;
        end
`ifdef AUTO_REPEAT_EN
        if (stable_high && sv[c]) begin
          m_hold[c]++;
          if (m_hold[c] == int'(RD) ||
              (m_hold[c] > int'(RD) && ((m_hold[c] - int'(RD)) % int'(RP)) == 0))
            m_re[c] = 1'b1;
        end else begin
          m_hold[c] = 0;
        end
`else
        if (stable_high) m_hold[c] = 0;
`endif
      end
    end
  endfunction

  // Drive one clock of stimulus; outputs are stable 1 time unit after the edge
  task automatic step(input logic [NB-1:0] raw, input logic rst);
    btn_raw    = raw;
    sync_reset = rst;
    @(posedge clk);
    model_edge(raw, rst);
    #1;
  endtask

  task automatic clean_start();
    step(2'b00, 1'b1);
    repeat (3) step(2'b00, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(2'b11, (i < 2) ? 1'b1 : 1'b0);
      checks++;
      if (btn_level !== 2'b00) begin
        errors++; $display("FAIL reset_level cycle %0d: got %b want 00", i, btn_level);
      end
      checks++;
      if (btn_re !== 2'b00) begin
        errors++; $display("FAIL reset_re cycle %0d: got %b want 00", i, btn_re);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [NB-1:0] exp_l, exp_r;
    clean_start();
    step(2'b01, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step(2'b01, 1'b0);
      exp_l = (i >= 5) ? 2'b01 : 2'b00;
      exp_r = (i == 5) ? 2'b01 : 2'b00;
      checks++;
      if (btn_level !== exp_l) begin
        errors++; $display("FAIL press_level k+%0d: got %b want %b", i, btn_level, exp_l);
      end
      checks++;
      if (btn_re !== exp_r) begin
        errors++; $display("FAIL press_re k+%0d: got %b want %b", i, btn_re, exp_r);
      end
    end
    for (int i = 0; i < 100; i++) begin
      step(2'b01, 1'b0);
      checks++;
      if (btn_re !== m_re || btn_level !== m_level) begin
        errors++; $display("FAIL hold_model cycle %0d: got re=%b lvl=%b want re=%b lvl=%b",
                           i, btn_re, btn_level, m_re, m_level);
      end
`ifndef AUTO_REPEAT_EN
      checks++;
      if (btn_re !== 2'b00) begin
        errors++; $display("FAIL hold_no_repeat cycle %0d: got %b want 00", i, btn_re);
      end
`endif
    end
  endtask

  task automatic test_bounce();
    logic pat [16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    clean_start();
    for (int i = 0; i < 16; i++) begin
      step({1'b0, pat[i]}, 1'b0);
      checks++;
      if (btn_level !== 2'b00 || btn_re !== 2'b00) begin
        errors++; $display("FAIL bounce cycle %0d: got lvl=%b re=%b want 00/00", i, btn_level, btn_re);
      end
      checks++;
      if (btn_level !== m_level || btn_re !== m_re) begin
        errors++; $display("FAIL bounce_model cycle %0d: got lvl=%b re=%b want lvl=%b re=%b",
                           i, btn_level, btn_re, m_level, m_re);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [NB-1:0] exp_r;
    clean_start();
    step(2'b11, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step(2'b11, 1'b0);
      exp_r = (i == 5) ? 2'b11 : 2'b00;
      checks++;
      if (btn_re !== exp_r) begin
        errors++; $display("FAIL simul_re k+%0d: got %b want %b", i, btn_re, exp_r);
      end
    end
  endtask

  task automatic test_release();
    logic [NB-1:0] exp_l;
    repeat (2) step(2'b11, 1'b0);
    step(2'b00, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step(2'b00, 1'b0);
      exp_l = (i >= 5) ? 2'b00 : 2'b11;
      checks++;
      if (btn_level !== exp_l) begin
        errors++; $display("FAIL release_level r+%0d: got %b want %b", i, btn_level, exp_l);
      end
      if (i >= 2) begin
        checks++;
        if (btn_re !== 2'b00) begin
          errors++; $display("FAIL release_re r+%0d: got %b want 00", i, btn_re);
        end
      end
      checks++;
      if (btn_re !== m_re) begin
        errors++; $display("FAIL release_model r+%0d: got %b want %b", i, btn_re, m_re);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [NB-1:0] exp_l;
    clean_start();
    for (int i = 0; i <= 3; i++) step(2'b01, 1'b0);
    step(2'b01, 1'b1);
    for (int i = 5; i <= 11; i++) begin
      step(2'b01, 1'b0);
      exp_l = (i >= 10) ? 2'b01 : 2'b00;
      checks++;
      if (btn_level !== exp_l) begin
        errors++; $display("FAIL midreset_level k+%0d: got %b want %b", i, btn_level, exp_l);
      end
      checks++;
      if (btn_re !== ((i == 10) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL midreset_re k+%0d: got %b want %b", i, btn_re,
                           (i == 10) ? 2'b01 : 2'b00);
      end
    end
  endtask

`ifdef AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    logic exp_r;
    clean_start();
    for (int i = 0; i <= 5; i++) step(2'b01, 1'b0);
    checks++;
    if (btn_re !== 2'b01) begin
      errors++; $display("FAIL repeat_press: got %b want 01", btn_re);
    end
    for (int off = 1; off <= 20; off++) begin
      step(2'b01, 1'b0);
      exp_r = (off == 10 || off == 13 || off == 16 || off == 19);
      checks++;
      if (btn_re[0] !== exp_r) begin
        errors++; $display("FAIL repeat P+%0d: got %b want %b", off, btn_re[0], exp_r);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [NB-1:0] cur;
    logic          rst;
    cur = '0;
    clean_start();
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NB; c++)
        if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
      rst = ($urandom_range(0, 299) == 0);
      step(cur, rst);
      checks++;
      if (btn_level !== m_level) begin
        errors++; $display("FAIL random_level cycle %0d: got %b want %b", i, btn_level, m_level);
      end
      checks++;
      if (btn_re !== m_re) begin
        errors++; $display("FAIL random_re cycle %0d: got %b want %b", i, btn_re, m_re);
      end
    end
  endtask

  initial begin
    btn_raw    = '0;
    sync_reset = 1'b1;
    model_edge('0, 1'b1);
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_release();
    test_reset_mid_count();
`ifdef AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
